// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle ARM control unit: state encoding,
// ALUControl codes, condition codes, datapath select encodings and the
// data-processing command decoder.
package mc_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned ALUOP_W = 3;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        MULWAIT = 4'd10
    } stateT;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_ORR = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_EOR = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_MOV = 3'b101;
    localparam logic [ALUOP_W-1:0] ALU_MUL = 3'b110;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // ImmSrc: 8-bit rotated DP immediate, 12-bit memory offset, 24-bit branch
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    // ResultSrc: registered ALU output, memory data, live ALU result
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALUSrcB: register operand, extended immediate, constant 4
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic [ALUOP_W-1:0] aluCtrl;
        logic               noWrite;
        logic               flagsAll;
        logic               flagsNZ;
    } dpCtrlT;

    // Map the DP cmd field to ALU op, write-back suppression and flag scope
    function automatic dpCtrlT dpDecode(input logic [3:0] cmd);
        dpCtrlT d;
        d = '{aluCtrl: ALU_ADD, noWrite: 1'b1, flagsAll: 1'b0, flagsNZ: 1'b0};
        case (cmd)
            4'b0100: d = '{aluCtrl: ALU_ADD, noWrite: 1'b0, flagsAll: 1'b1, flagsNZ: 1'b0};
            4'b0010: d = '{aluCtrl: ALU_SUB, noWrite: 1'b0, flagsAll: 1'b1, flagsNZ: 1'b0};
            4'b0000: d = '{aluCtrl: ALU_AND, noWrite: 1'b0, flagsAll: 1'b0, flagsNZ: 1'b1};
            4'b1100: d = '{aluCtrl: ALU_ORR, noWrite: 1'b0, flagsAll: 1'b0, flagsNZ: 1'b1};
            4'b0001: d = '{aluCtrl: ALU_EOR, noWrite: 1'b0, flagsAll: 1'b0, flagsNZ: 1'b1};
            4'b1101: d = '{aluCtrl: ALU_MOV, noWrite: 1'b0, flagsAll: 1'b0, flagsNZ: 1'b1};
            4'b1010: d = '{aluCtrl: ALU_SUB, noWrite: 1'b1, flagsAll: 1'b1, flagsNZ: 1'b0};
            4'b1011: d = '{aluCtrl: ALU_ADD, noWrite: 1'b1, flagsAll: 1'b1, flagsNZ: 1'b0};
            default: d = '{aluCtrl: ALU_ADD, noWrite: 1'b1, flagsAll: 1'b0, flagsNZ: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_control_unit_cond_check.sv
// Combinational ARM condition evaluation against registered NZCV flags.
module cond_check
    import mc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condEx_c
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    // Evaluate the 15 defined codes; 1111 never executes
    always_comb begin
        condEx_c = 1'b0;
        case (cond)
            COND_EQ: condEx_c = z;
            COND_NE: condEx_c = ~z;
            COND_CS: condEx_c = c;
            COND_CC: condEx_c = ~c;
            COND_MI: condEx_c = n;
            COND_PL: condEx_c = ~n;
            COND_VS: condEx_c = v;
            COND_VC: condEx_c = ~v;
            COND_HI: condEx_c = c & ~z;
            COND_LS: condEx_c = ~c | z;
            COND_GE: condEx_c = (n == v);
            COND_LT: condEx_c = (n != v);
            COND_GT: condEx_c = ~z & (n == v);
            COND_LE: condEx_c = z | (n != v);
            COND_AL: condEx_c = 1'b1;
            default: condEx_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle ARM control unit: Moore FSM driving datapath strobes/selects,
// internal NZCV flag register and conditional execution.
// Optional multiply support is enabled by defining MC_MUL_EN.
module mc_control_unit
    import mc_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3,
    parameter int unsigned MUL_LAT   = 4
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic [31:0]          Instr,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic                 MemW,
    output logic                 RegW,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           State
);

    stateT              state, stateNext;
    logic [3:0]         flags;
    logic               condEx;
    logic               flagWrAll, flagWrNZ;
    logic               rdIsPc;
    logic [ALUOP_W-1:0] aluCtrl;
    dpCtrlT             dp;
    logic               unusedInstr;

    assign dp         = dpDecode(Instr[24:21]);
    assign ALUControl = ALUCTRL_W'(aluCtrl);
    assign State      = state;

    cond_check uCond (
        .cond    (Instr[31:28]),
        .flags   (flags),
        .condEx_c(condEx)
    );

`ifdef MC_MUL_EN
    logic       isMul;
    logic [3:0] mulCnt;

    assign isMul       = (Instr[27:22] == 6'b000000) && (Instr[7:4] == 4'b1001);
    assign rdIsPc      = isMul ? (Instr[19:16] == 4'hF) : (Instr[15:12] == 4'hF);
    assign unusedInstr = ^{Instr[11:8], Instr[3:0]};

    // Multiply latency down-counter, loaded on entry to MULWAIT
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            mulCnt <= 4'd0;
        end else if (state == EXECR && isMul) begin
            mulCnt <= 4'(MUL_LAT);
        end else if (state == MULWAIT && mulCnt != 4'd0) begin
            mulCnt <= mulCnt - 4'd1;
        end
    end
`else
    assign rdIsPc      = (Instr[15:12] == 4'hF);
    assign unusedInstr = ^{Instr[19:16], Instr[11:0], 4'(MUL_LAT)};
`endif

    // State register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    // Condition flag register; logical ops and MUL only touch N and Z
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            flags <= 4'b0000;
        end else if (flagWrAll) begin
            flags <= ALUFlags;
        end else if (flagWrNZ) begin
            flags[3:2] <= ALUFlags[3:2];
        end
    end

    // Next-state and Moore output decode; everything forced low in reset
    always_comb begin
        stateNext = state;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemW      = 1'b0;
        RegW      = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        ImmSrc    = IMM_DP;
        RegSrc    = 2'b00;
        aluCtrl   = ALU_ADD;
        flagWrAll = 1'b0;
        flagWrNZ  = 1'b0;

        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                stateNext = DECODE;
            end
            DECODE: begin
                case (Instr[27:26])
                    2'b00:   stateNext = Instr[25] ? EXECI : EXECR;
                    2'b01:   stateNext = MEMADR;
                    2'b10:   stateNext = BRANCH;
                    default: stateNext = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_MEM;
                aluCtrl   = Instr[23] ? ALU_ADD : ALU_SUB;
                RegSrc[1] = ~Instr[20];
                stateNext = Instr[20] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc    = 1'b1;
                stateNext = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_MEM;
                RegW      = condEx;
                PCWrite   = condEx & rdIsPc;
                stateNext = FETCH;
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                MemW      = condEx;
                RegSrc[1] = 1'b1;
                stateNext = FETCH;
            end
            EXECR, EXECI: begin
                if (state == EXECI) begin
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = IMM_DP;
                end
                aluCtrl   = dp.aluCtrl;
                flagWrAll = condEx & Instr[20] & dp.flagsAll;
                flagWrNZ  = condEx & Instr[20] & dp.flagsNZ;
                stateNext = ALUWB;
`ifdef MC_MUL_EN
                if (state == EXECR && isMul) begin
                    aluCtrl   = ALU_MUL;
                    flagWrAll = 1'b0;
                    flagWrNZ  = 1'b0;
                    stateNext = MULWAIT;
                end
`endif
            end
`ifdef MC_MUL_EN
            MULWAIT: begin
                aluCtrl = ALU_MUL;
                if (mulCnt <= 4'd1) begin
                    flagWrNZ  = condEx & Instr[20];
                    stateNext = ALUWB;
                end
            end
`endif
            ALUWB: begin
                RegW      = condEx & ~dp.noWrite;
                PCWrite   = condEx & ~dp.noWrite & rdIsPc;
                stateNext = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_BR;
                ResultSrc = RES_ALU;
                RegSrc[0] = 1'b1;
                PCWrite   = condEx;
                stateNext = FETCH;
            end
            default: stateNext = FETCH;
        endcase

        if (!RESETn) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            AdrSrc    = 1'b0;
            MemW      = 1'b0;
            RegW      = 1'b0;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 2'b00;
            ResultSrc = 2'b00;
            ImmSrc    = 2'b00;
            RegSrc    = 2'b00;
            aluCtrl   = ALU_ADD;
            flagWrAll = 1'b0;
            flagWrNZ  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed testbench for mc_control_unit: per-cycle state and strobe checks.
module tb_mc_control_unit;

    logic        CLK;
    logic        RESETn;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, IRWrite, AdrSrc, MemW, RegW, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  State;

    int nChecks = 0;
    int nFails  = 0;

    // {PCWrite,IRWrite,AdrSrc,MemW,RegW,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,RegSrc,ALUControl}
    localparam logic [16:0] O_F      = 17'b1_1_0_0_0_1_10_10_00_00_000;
    localparam logic [16:0] O_Z      = 17'b0;
    localparam logic [16:0] O_WB     = 17'b0_0_0_0_1_0_00_00_00_00_000;
    localparam logic [16:0] O_WBPC   = 17'b1_0_0_0_1_0_00_00_00_00_000;
    localparam logic [16:0] O_LDRADR = 17'b0_0_0_0_0_0_01_00_01_00_000;
    localparam logic [16:0] O_STRADR = 17'b0_0_0_0_0_0_01_00_01_10_000;
    localparam logic [16:0] O_MEMRD  = 17'b0_0_1_0_0_0_00_00_00_00_000;
    localparam logic [16:0] O_MEMWB  = 17'b0_0_0_0_1_0_00_01_00_00_000;
    localparam logic [16:0] O_MEMWR  = 17'b0_0_1_1_0_0_00_00_00_10_000;
    localparam logic [16:0] O_CMP    = 17'b0_0_0_0_0_0_01_00_00_00_001;
    localparam logic [16:0] O_BT     = 17'b1_0_0_0_0_0_01_10_10_01_000;
    localparam logic [16:0] O_BN     = 17'b0_0_0_0_0_0_01_10_10_01_000;
    localparam logic [16:0] O_AND    = 17'b0_0_0_0_0_0_00_00_00_00_010;
    localparam logic [16:0] O_MUL    = 17'b0_0_0_0_0_0_00_00_00_00_110;

    mc_control_unit #(.ALUCTRL_W(3), .MUL_LAT(4)) dut (
        .CLK(CLK), .RESETn(RESETn), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemW(MemW),
        .RegW(RegW), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State)
    );

    always #5 CLK = ~CLK;

    function automatic logic [16:0] snap();
        return {PCWrite, IRWrite, AdrSrc, MemW, RegW, ALUSrcA,
                ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};
    endfunction

    task automatic test_reset();
        RESETn = 1'b0; Instr = 32'h0; ALUFlags = 4'h0;
        #1;
        nChecks++;
        if (State !== 4'd0 || snap() !== O_Z) begin
            nFails++;
            $display("FAIL reset_early: state=%0d outs=%05h expected state=0 outs=%05h", State, snap(), O_Z);
        end
        repeat (2) @(posedge CLK);
        #1;
        nChecks++;
        if (State !== 4'd0 || snap() !== O_Z) begin
            nFails++;
            $display("FAIL reset_hold: state=%0d outs=%05h expected state=0 outs=%05h", State, snap(), O_Z);
        end
        RESETn = 1'b1;
        #1;
        nChecks++;
        if (State !== 4'd0 || snap() !== O_F) begin
            nFails++;
            $display("FAIL reset_release: state=%0d outs=%05h expected state=0 outs=%05h", State, snap(), O_F);
        end
    endtask

    task automatic test_add();
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd6, 4'd8};
        logic [16:0] eo [4] = '{O_F, O_Z, O_Z, O_WB};
        for (int i = 0; i < 4; i++) begin
            Instr = 32'hE0821003; ALUFlags = 4'h0;
            #1;
            nChecks++;
            if (State !== es[i] || snap() !== eo[i]) begin
                nFails++;
                $display("FAIL add cyc%0d: state=%0d outs=%05h expected state=%0d outs=%05h", i, State, snap(), es[i], eo[i]);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_ldr_str();
        logic [31:0] ti [9] = '{32'hE5921004, 32'hE5921004, 32'hE5921004, 32'hE5921004, 32'hE5921004,
                                32'hE5821004, 32'hE5821004, 32'hE5821004, 32'hE5821004};
        logic [3:0]  es [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd5};
        logic [16:0] eo [9] = '{O_F, O_Z, O_LDRADR, O_MEMRD, O_MEMWB, O_F, O_Z, O_STRADR, O_MEMWR};
        for (int i = 0; i < 9; i++) begin
            Instr = ti[i];
            #1;
            nChecks++;
            if (State !== es[i] || snap() !== eo[i]) begin
                nFails++;
                $display("FAIL ldr_str cyc%0d: state=%0d outs=%05h expected state=%0d outs=%05h", i, State, snap(), es[i], eo[i]);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_cmp_beq();
        logic [31:0] ti [14] = '{32'hE3510000, 32'hE3510000, 32'hE3510000, 32'hE3510000,
                                 32'h0A000002, 32'h0A000002, 32'h0A000002,
                                 32'hE3510000, 32'hE3510000, 32'hE3510000, 32'hE3510000,
                                 32'h0A000002, 32'h0A000002, 32'h0A000002};
        logic [3:0]  tf [14] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4,
                                 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic [3:0]  es [14] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0, 4'd1, 4'd9,
                                 4'd0, 4'd1, 4'd7, 4'd8, 4'd0, 4'd1, 4'd9};
        logic [16:0] eo [14] = '{O_F, O_Z, O_CMP, O_Z, O_F, O_Z, O_BT,
                                 O_F, O_Z, O_CMP, O_Z, O_F, O_Z, O_BN};
        for (int i = 0; i < 14; i++) begin
            Instr = ti[i]; ALUFlags = tf[i];
            #1;
            nChecks++;
            if (State !== es[i] || snap() !== eo[i]) begin
                nFails++;
                $display("FAIL cmp_beq cyc%0d: state=%0d outs=%05h expected state=%0d outs=%05h", i, State, snap(), es[i], eo[i]);
            end
            @(posedge CLK); #1;
        end
        ALUFlags = 4'h0;
    endtask

    // flags are 0000 here: ADDEQ must not write, ADDNE must
    task automatic test_cond();
        logic [31:0] ti [8] = '{32'h00821003, 32'h00821003, 32'h00821003, 32'h00821003,
                                32'h10821003, 32'h10821003, 32'h10821003, 32'h10821003};
        logic [3:0]  es [8] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 4'd1, 4'd6, 4'd8};
        logic [16:0] eo [8] = '{O_F, O_Z, O_Z, O_Z, O_F, O_Z, O_Z, O_WB};
        for (int i = 0; i < 8; i++) begin
            Instr = ti[i];
            #1;
            nChecks++;
            if (State !== es[i] || snap() !== eo[i]) begin
                nFails++;
                $display("FAIL cond cyc%0d: state=%0d outs=%05h expected state=%0d outs=%05h", i, State, snap(), es[i], eo[i]);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_pc_dest();
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd6, 4'd8};
        logic [16:0] eo [4] = '{O_F, O_Z, O_Z, O_WBPC};
        for (int i = 0; i < 4; i++) begin
            Instr = 32'hE082F003;
            #1;
            nChecks++;
            if (State !== es[i] || snap() !== eo[i]) begin
                nFails++;
                $display("FAIL pc_dest cyc%0d: state=%0d outs=%05h expected state=%0d outs=%05h", i, State, snap(), es[i], eo[i]);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_mul();
`ifdef MC_MUL_EN
        localparam int N = 8;
        logic [3:0]  es [N] = '{4'd0, 4'd1, 4'd6, 4'd10, 4'd10, 4'd10, 4'd10, 4'd8};
        logic [16:0] eo [N] = '{O_F, O_Z, O_MUL, O_MUL, O_MUL, O_MUL, O_MUL, O_WB};
`else
        localparam int N = 4;
        logic [3:0]  es [N] = '{4'd0, 4'd1, 4'd6, 4'd8};
        logic [16:0] eo [N] = '{O_F, O_Z, O_AND, O_WB};
`endif
        for (int i = 0; i < N; i++) begin
            Instr = 32'hE0010392;
            #1;
            nChecks++;
            if (State !== es[i] || snap() !== eo[i]) begin
                nFails++;
                $display("FAIL mul cyc%0d: state=%0d outs=%05h expected state=%0d outs=%05h", i, State, snap(), es[i], eo[i]);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
        logic [16:0] eo [4] = '{O_F, O_Z, O_LDRADR, O_MEMRD};
        for (int i = 0; i < 4; i++) begin
            Instr = 32'hE5921004;
            #1;
            nChecks++;
            if (State !== es[i] || snap() !== eo[i]) begin
                nFails++;
                $display("FAIL reset_mid cyc%0d: state=%0d outs=%05h expected state=%0d outs=%05h", i, State, snap(), es[i], eo[i]);
            end
            if (i < 3) begin
                @(posedge CLK); #1;
            end
        end
        #2 RESETn = 1'b0;
        #1;
        nChecks++;
        if (State !== 4'd0 || snap() !== O_Z) begin
            nFails++;
            $display("FAIL reset_mid_async: state=%0d outs=%05h expected state=0 outs=%05h", State, snap(), O_Z);
        end
        @(posedge CLK); #1;
        nChecks++;
        if (State !== 4'd0 || snap() !== O_Z) begin
            nFails++;
            $display("FAIL reset_mid_hold: state=%0d outs=%05h expected state=0 outs=%05h", State, snap(), O_Z);
        end
        RESETn = 1'b1;
        #1;
        nChecks++;
        if (State !== 4'd0 || snap() !== O_F) begin
            nFails++;
            $display("FAIL reset_mid_release: state=%0d outs=%05h expected state=0 outs=%05h", State, snap(), O_F);
        end
    endtask

    task automatic test_undefined();
        logic [3:0]  es [3] = '{4'd0, 4'd1, 4'd0};
        logic [16:0] eo [3] = '{O_F, O_Z, O_F};
        for (int i = 0; i < 3; i++) begin
            Instr = 32'hEC000000;
            #1;
            nChecks++;
            if (State !== es[i] || snap() !== eo[i]) begin
                nFails++;
                $display("FAIL undefined cyc%0d: state=%0d outs=%05h expected state=%0d outs=%05h", i, State, snap(), es[i], eo[i]);
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        CLK = 1'b0;
        test_reset();
        test_add();
        test_ldr_str();
        test_cmp_beq();
        test_cond();
        test_pc_dest();
        test_mul();
        test_reset_mid();
        test_undefined();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter ALUCTRL_W, default 3: ALUControl width; SHALL be >= 3.
REQ-002 Parameter MUL_LAT, default 4: MUL execute cycles; SHALL be 1..15.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RESETn  in  1  asynchronous, active-low reset.
REQ-005 Instr  in  32  instruction register contents; valid from DECODE onward.
REQ-006 ALUFlags  in  4  NZCV from ALU, current cycle.
REQ-007 PCWrite, IRWrite, AdrSrc, MemW, RegW, ALUSrcA  out  1 each  datapath strobes/selects.
REQ-008 ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2 each  datapath selects.
REQ-009 ALUControl  out  ALUCTRL_W  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV (pass B), 110 MUL.
REQ-010 State  out  4  current FSM state, for debug.

Function
REQ-011 Moore FSM: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, MULWAIT.
REQ-012 FETCH: IRWrite=1, PCWrite=1 (PC+4), AdrSrc=0; next DECODE.
REQ-013 DECODE, Instr[27:26]: 00 -> EXECI if Instr[25]=1, else EXECR; 01 -> MEMADR; 10 -> BRANCH; 11 -> FETCH, no writes (undefined opcode).
REQ-014 MEMADR: ALUSrcB=imm, ADD if Instr[23]=1 else SUB; next MEMRD if Instr[20]=1, else MEMWR.
REQ-015 MEMRD -> MEMWB (RegW, ResultSrc=mem) -> FETCH; MEMWR: MemW=1 -> FETCH.
REQ-016 EXECR/EXECI -> ALUWB; ALUWB asserts RegW unless NoWrite, then FETCH.
REQ-017 DP cmd Instr[24:21]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV, 1010 CMP (SUB, NoWrite), 1011 CMN (ADD, NoWrite); any other cmd: NoWrite=1, no flag write.
REQ-018 Internal 4-bit flag register; written in EXECR/EXECI only when Instr[20]=1 and CondEx=1: ADD/SUB/CMP/CMN write NZCV; AND/ORR/EOR/MOV write NZ only.
REQ-019 CondEx from Instr[31:28] vs registered flags, all 15 ARM codes (EQ..AL); 1111 = never.
REQ-020 CondEx=0: RegW, MemW, flag write, branch PCWrite forced 0; state sequence unchanged.
REQ-021 Rd=1111 with RegW in ALUWB/MEMWB additionally asserts PCWrite (result to PC).
REQ-022 BRANCH: ImmSrc=10, ADD, PCWrite=CondEx; next FETCH.
REQ-023 RegSrc: bit0=1 in BRANCH; bit1=1 in MEMADR/MEMWR for store.
REQ-024 Outputs not listed for a state SHALL be 0; no X or latched values.
REQ-025 Instruction latency: DP 4 cycles, LDR 5, STR 4, B 3.

Reset
REQ-026 RESETn low: State=FETCH, flags=0000, MUL counter=0, immediately and independent of CLK.
REQ-027 During reset all outputs SHALL be 0 except State=FETCH; first FETCH strobes occur in the first cycle after release.
REQ-028 Reset mid-instruction abandons it; no RegW/MemW/flag write occurs after assertion.

Configuration
REQ-029 Macro MC_MUL_EN defined: MUL decoded when Instr[27:22]=000000 and Instr[7:4]=1001; EXECR -> MULWAIT, ALUControl=110 held for MUL_LAT cycles via down-counter, then ALUWB; Instr[20] updates NZ only.
REQ-030 Macro undefined: MULWAIT, counter and MUL decode absent; such encodings execute as AND per REQ-017.

Structure
REQ-031 Shared package mc_pkg: state encoding, ALUControl codes, condition-code constants, ImmSrc/ResultSrc encodings.
REQ-032 One sub-module cond_check: combinational CondEx from cond field and flags.

Verification
REQ-033 0xE0821003 (ADD R1,R2,R3) -> FETCH,DECODE,EXECR,ALUWB; RegW=1 only in ALUWB; ALUControl=000.
REQ-034 0xE5921004 (LDR) -> 5 states ending MEMWB, RegW=1, ResultSrc=mem; 0xE5821004 (STR) -> MemW=1 in MEMWR only.
REQ-035 0xE3510000 (CMP R1,#0), ALUFlags=0100 -> flags=0100, RegW=0; then 0x0A000002 (BEQ) -> PCWrite=1 in BRANCH; with flags=0000 -> PCWrite=0.
REQ-036 RESETn low during MEMRD -> State=FETCH asynchronously, no RegW pulse; after release normal FETCH.
REQ-037 MC_MUL_EN, MUL_LAT=4, 0xE0010392 -> MULWAIT exactly 4 cycles then ALUWB RegW=1; undefined: 4-cycle AND flow.
REQ-038 Instr[27:26]=11 -> FETCH,DECODE,FETCH with no write strobes.
